// File: rtl/wb_fuzz_responder.sv
// Wishbone classic register responder with programmable ack latency, error
// injection on bad addresses, a hang mode and an error-sticky interrupt.
module wb_fuzz_responder #(
    parameter int unsigned NUM_REGS      = 16,
    parameter int unsigned RESET_LATENCY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wb_addr,
    input  logic [31:0] wb_data,
    input  logic [3:0]  wb_sel,
    input  logic        wb_stb,
    input  logic        wb_cyc,
    input  logic        wb_we,
    output logic [31:0] wb_data_o,
    output logic        wb_ack,
    output logic        wb_err,
    output logic        int_
);

    localparam int unsigned IW         = $clog2(NUM_REGS);
    localparam logic [31:0] ADDR_LIMIT = 32'(NUM_REGS * 4);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        fire_c;

    logic [31:0] addr_q, data_q;
    logic [3:0]  sel_q;
    logic        we_q;

    logic [3:0]  lat;
    logic        int_en, hang_en, err_sticky;
    logic [15:0] acc_cnt;
    logic [31:0] scratch [NUM_REGS];

    logic [31:0] req_addr, req_data, rd_c, mask_c;
    logic [3:0]  req_sel;
    logic        req_we, req_err;
    logic [IW-1:0] req_idx;

    // In IDLE the live bus is the request (zero-latency path); otherwise the captured copy.
    always_comb begin
        req_addr = addr_q;
        req_data = data_q;
        req_sel  = sel_q;
        req_we   = we_q;
        if (state == S_IDLE) begin
            req_addr = wb_addr;
            req_data = wb_data;
            req_sel  = wb_sel;
            req_we   = wb_we;
        end
    end

    assign req_idx = req_addr[IW+1:2];
    assign req_err = (req_addr[1:0] != 2'b00) || (req_addr >= ADDR_LIMIT);
    assign mask_c  = {{8{req_sel[3]}}, {8{req_sel[2]}}, {8{req_sel[1]}}, {8{req_sel[0]}}};

    always_comb begin
        rd_c = scratch[req_idx];
        if (req_idx == '0)
            rd_c = {22'b0, hang_en, int_en, 4'b0, lat};
        else if (req_idx == IW'(1))
            rd_c = {15'b0, err_sticky, acc_cnt};
    end

    // Next-state logic; fire_c marks the single edge on which a transaction completes.
    // CTRL accesses ignore HANG_EN so software can always release a hung responder.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        fire_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (wb_cyc && wb_stb) begin
                    cnt_n = lat;
                    if (lat == 4'd0) begin
                        state_n = S_RESP;
                        fire_c  = 1'b1;
                    end else begin
                        state_n = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!wb_cyc) begin
                    state_n = S_IDLE;
                end else if (!(hang_en && (req_idx != '0))) begin
                    if (cnt <= 4'd1) begin
                        state_n = S_RESP;
                        fire_c  = 1'b1;
                    end else begin
                        cnt_n = cnt - 4'd1;
                    end
                end
            end
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            data_q <= '0;
            sel_q  <= '0;
            we_q   <= 1'b0;
        end else if ((state == S_IDLE) && wb_cyc && wb_stb) begin
            addr_q <= wb_addr;
            data_q <= wb_data;
            sel_q  <= wb_sel;
            we_q   <= wb_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_ack    <= 1'b0;
            wb_err    <= 1'b0;
            wb_data_o <= '0;
            int_      <= 1'b0;
        end else begin
            wb_ack    <= fire_c && !req_err;
            wb_err    <= fire_c && req_err;
            wb_data_o <= (fire_c && !req_err && !req_we) ? rd_c : '0;
            int_      <= int_en & err_sticky;
        end
    end

    // Register file; all updates land on the completing edge together with the access count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat        <= 4'(RESET_LATENCY);
            int_en     <= 1'b0;
            hang_en    <= 1'b0;
            acc_cnt    <= '0;
            err_sticky <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) scratch[i] <= '0;
        end else if (fire_c) begin
            if (acc_cnt != 16'hFFFF) acc_cnt <= acc_cnt + 16'd1;
            if (req_err) begin
                err_sticky <= 1'b1;
            end else if (req_we) begin
                if (req_idx == '0) begin
                    if (req_sel[0]) lat <= req_data[3:0];
                    if (req_sel[1]) begin
                        int_en  <= req_data[8];
                        hang_en <= req_data[9];
                    end
                end else if (req_idx == IW'(1)) begin
                    if (req_sel[2] && req_data[16]) err_sticky <= 1'b0;
                end else begin
                    scratch[req_idx] <= (scratch[req_idx] & ~mask_c) | (req_data & mask_c);
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_fuzz_responder.sv
// Scoreboard bench for wb_fuzz_responder: a register model predicts each
// termination (kind, data, cycle) and the monitor checks them as they appear.
module tb_wb_fuzz_responder;

    localparam int unsigned NUM_REGS = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wb_addr, wb_data, wb_data_o;
    logic [3:0]  wb_sel;
    logic        wb_stb, wb_cyc, wb_we, wb_ack, wb_err, int_;

    wb_fuzz_responder #(.NUM_REGS(NUM_REGS), .RESET_LATENCY(0)) dut (
        .clk(clk), .rst_n(rst_n), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_sel(wb_sel), .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_we(wb_we),
        .wb_data_o(wb_data_o), .wb_ack(wb_ack), .wb_err(wb_err), .int_(int_)
    );

    always #5 clk = ~clk;

    int unsigned edges = 0;
    always @(posedge clk) edges++;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int unsigned due;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    // Reference register model
    logic [3:0]  m_lat;
    logic        m_int_en, m_hang, m_sticky;
    logic [15:0] m_acc;
    logic [31:0] m_scr [NUM_REGS];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lat = 4'd0; m_int_en = 1'b0; m_hang = 1'b0; m_sticky = 1'b0; m_acc = 16'd0;
        for (int i = 0; i < int'(NUM_REGS); i++) m_scr[i] = 32'd0;
    endtask

    always @(negedge clk) begin
        if (rst_n && (wb_ack || wb_err)) begin
            if (sb.size() == 0) begin
                check_eq("spurious_term", {30'd0, wb_err, wb_ack}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq({mon_e.tag, "_err"},   {31'd0, wb_err}, {31'd0, mon_e.err});
                check_eq({mon_e.tag, "_ack"},   {31'd0, wb_ack}, {31'd0, !mon_e.err});
                check_eq({mon_e.tag, "_data"},  wb_data_o, mon_e.data);
                check_eq({mon_e.tag, "_cycle"}, edges, mon_e.due);
            end
        end
    end

    task automatic bus_idle();
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_addr = 32'd0; wb_data = 32'd0; wb_sel = 4'd0;
    endtask

    task automatic access(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] sel, input logic we);
        exp_t        e;
        logic        err, done, int_pre;
        int          idx;
        logic [31:0] rd, mask;
        err  = (addr[1:0] != 2'b00) || (addr >= 32'(NUM_REGS * 4));
        idx  = int'((addr >> 2) & 32'(NUM_REGS - 1));
        rd   = m_scr[idx];
        if (idx == 0) rd = {22'd0, m_hang, m_int_en, 4'd0, m_lat};
        if (idx == 1) rd = {15'd0, m_sticky, m_acc};
        mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        int_pre = m_int_en & m_sticky;
        e.err  = err;
        e.data = (!err && !we) ? rd : 32'd0;
        e.tag  = tag;
        @(posedge clk); #1;
        wb_addr = addr; wb_data = data; wb_sel = sel; wb_we = we;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        e.due = edges + 1 + int'(m_lat);
        sb.push_back(e);
        if (err) begin
            m_sticky = 1'b1;
        end else if (we) begin
            if (idx == 0) begin
                if (sel[0]) m_lat = data[3:0];
                if (sel[1]) begin m_int_en = data[8]; m_hang = data[9]; end
            end else if (idx == 1) begin
                if (sel[2] && data[16]) m_sticky = 1'b0;
            end else begin
                m_scr[idx] = (m_scr[idx] & ~mask) | (data & mask);
            end
        end
        if (m_acc != 16'hFFFF) m_acc = m_acc + 16'd1;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (wb_ack || wb_err) done = 1'b1;
        end
        check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
        if (done) check_eq({tag, "_int_pre"}, {31'd0, int_}, {31'd0, int_pre});
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        check_eq({tag, "_int_post"}, {31'd0, int_}, {31'd0, m_int_en & m_sticky});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [31:0] ra;
        bus_idle();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ack",  {31'd0, wb_ack}, 32'd0);
        check_eq("rst_err",  {31'd0, wb_err}, 32'd0);
        check_eq("rst_data", wb_data_o, 32'd0);
        check_eq("rst_int",  {31'd0, int_}, 32'd0);

        access("wr_scr2",  32'h08, 32'hDEADBEEF, 4'hF, 1'b1);
        access("rd_scr2",  32'h08, 32'h0, 4'hF, 1'b0);
        access("rd_stat2", 32'h04, 32'h0, 4'hF, 1'b0);

        access("wr_lat3",  32'h00, 32'h3, 4'hF, 1'b1);
        access("rd_scr3",  32'h0C, 32'h0, 4'hF, 1'b0);
        access("wr_sel5",  32'h10, 32'hFFFFFFFF, 4'b0101, 1'b1);
        access("rd_sel5",  32'h10, 32'h0, 4'hF, 1'b0);
        access("wr_lat0",  32'h00, 32'h0, 4'hF, 1'b1);

        access("err_oob",  32'h40, 32'h12345678, 4'hF, 1'b1);
        access("err_mis",  32'h09, 32'h0, 4'hF, 1'b0);
        access("rd_stick", 32'h04, 32'h0, 4'hF, 1'b0);
        access("wr_inten", 32'h00, 32'h100, 4'hF, 1'b1);
        access("w1c_nosel", 32'h04, 32'h00010000, 4'b1011, 1'b1);
        access("w1c_clr",  32'h04, 32'h00010000, 4'hF, 1'b1);
        access("rd_clr",   32'h04, 32'h0, 4'hF, 1'b0);

        access("wr_lat1",  32'h00, 32'h1, 4'hF, 1'b1);
        for (int i = 0; i < 20; i++) begin
            ra = 32'($urandom_range(NUM_REGS - 1, 2)) << 2;
            access("rnd", ra, $urandom, 4'($urandom), 1'($urandom));
        end
        for (int i = 2; i < int'(NUM_REGS); i++) access("rnd_rd", 32'(i) << 2, 32'h0, 4'hF, 1'b0);

        // Hang: no termination for 300 cycles, abort, then release through CTRL.
        access("wr_hang",  32'h00, 32'h203, 4'hF, 1'b1);
        @(posedge clk); #1;
        wb_addr = 32'h08; wb_sel = 4'hF; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        repeat (300) @(negedge clk);
        check_eq("hang_ack", {31'd0, wb_ack}, 32'd0);
        @(posedge clk); #1;
        bus_idle();
        access("release",  32'h00, 32'h000, 4'hF, 1'b1);
        access("rd_after_hang", 32'h04, 32'h0, 4'hF, 1'b0);
        access("rd_scr2_hang",  32'h08, 32'h0, 4'hF, 1'b0);

        // Reset during WAIT drops the transaction and restores reset values.
        access("wr_lat5",  32'h00, 32'h5, 4'hF, 1'b1);
        @(posedge clk); #1;
        wb_addr = 32'h08; wb_data = 32'h55AA55AA; wb_sel = 4'hF; wb_we = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus_idle();
        model_reset();
        repeat (8) @(negedge clk);
        check_eq("post_rst_ack", {31'd0, wb_ack}, 32'd0);
        access("rst_rd_ctrl", 32'h00, 32'h0, 4'hF, 1'b0);
        access("rst_rd_stat", 32'h04, 32'h0, 4'hF, 1'b0);
        access("rst_rd_s2",   32'h08, 32'h0, 4'hF, 1'b0);
        access("rst_rd_s4",   32'h10, 32'h0, 4'hF, 1'b0);

        repeat (4) @(negedge clk);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_fuzz_responder.md
WB_FUZZ_RESPONDER -- requirements
Module: wb_fuzz_responder

Interface
REQ-001 Parameter NUM_REGS, default 16, number of 32-bit word registers (power of 2, 4..64).
REQ-002 Parameter RESET_LATENCY, default 0, reset value of CTRL[3:0] (0..15).
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 wb_addr  input  32  byte address from initiator.
REQ-006 wb_data  input  32  write data.
REQ-007 wb_sel  input  4  byte enables; bit i covers bits [8i+7:8i].
REQ-008 wb_stb, wb_cyc, wb_we  input  1 each  Wishbone classic strobe, cycle, write enable.
REQ-009 wb_data_o  output  32  read data, registered.
REQ-010 wb_ack  output  1  normal termination, registered, single-cycle pulse.
REQ-011 wb_err  output  1  error termination, registered, single-cycle pulse.
REQ-012 int_  output  1  interrupt level, registered.

Function
REQ-013 Register map, index = wb_addr[$clog2(NUM_REGS)+1:2]: 0 CTRL (RW: [3:0] LAT, [8] INT_EN, [9] HANG_EN, others read 0); 1 STATUS (RO [15:0] ACC_CNT, W1C [16] ERR_STICKY); 2..NUM_REGS-1 scratch RW.
REQ-014 FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-015 IDLE: when wb_cyc&wb_stb sampled high, capture addr/data/sel/we and load wait counter = LAT; go to RESP if LAT==0, else WAIT.
REQ-016 WAIT: counter decrements by 1 per cycle; go to RESP the cycle after counter reaches 1; with HANG_EN=1, never leave WAIT except on abort.
REQ-017 Abort: wb_cyc low in WAIT, or at the RESP transition -> return to IDLE, no ack/err, no register update, ACC_CNT unchanged.
REQ-018 Latency: request first sampled in cycle N -> wb_ack or wb_err high in cycle N+1+LAT, for exactly one cycle.
REQ-019 Error condition: wb_addr[1:0]!=0, or wb_addr >= NUM_REGS*4; then wb_err=1, wb_ack=0, no write, ERR_STICKY set.
REQ-020 Valid write: on the ack cycle, update only the bytes enabled by wb_sel; STATUS write clears ERR_STICKY iff wb_data[16]=1 and wb_sel[2]=1; ACC_CNT not writable.
REQ-021 Valid read: wb_data_o = register value on the ack cycle; wb_data_o = 0 in all other cycles, including write acks and err cycles.
REQ-022 ACC_CNT increments by 1 on each ack or err cycle, saturating at 0xFFFF.
REQ-023 Write to STATUS: the ACC_CNT increment and the ERR_STICKY clear both take effect on the same cycle.
REQ-024 RESP returns to IDLE; stb still high in the next cycle starts a new transaction (back-to-back, 2+LAT cycles per access).
REQ-025 CTRL writes take effect for the next transaction; the in-flight counter is not reloaded.
REQ-026 int_ = INT_EN & ERR_STICKY, registered (one-cycle delay after either changes).

Reset
REQ-027 Reset in any state: state IDLE, wb_ack=0, wb_err=0, wb_data_o=0, int_=0, CTRL={HANG_EN=0, INT_EN=0, LAT=RESET_LATENCY}, STATUS=0, scratch registers=0.
REQ-028 Reset mid-transaction drops the transaction: no ack/err and no write in the cycle after rst_n rises.

Verification
REQ-029 LAT=0: write 0xDEADBEEF to 0x08 with sel=1111 -> ack in cycle N+1; read 0x08 -> wb_data_o=0xDEADBEEF on ack; ACC_CNT=2.
REQ-030 Write CTRL=0x3, then read 0x0C -> ack exactly at cycle N+4; no ack at N+1..N+3.
REQ-031 Write 0xFFFFFFFF to 0x10 with sel=0101 -> read returns 0x00FF00FF.
REQ-032 Access 0x40 (NUM_REGS=16) and 0x09 -> wb_err pulses, no ack, ERR_STICKY=1; with INT_EN=1, int_ goes high; write STATUS 0x00010000 -> int_ low one cycle later.
REQ-033 HANG_EN=1, access 0x08 -> no ack for 300 cycles; drop wb_cyc -> IDLE, ACC_CNT unchanged; clear HANG_EN, next access acks.
REQ-034 Pulse rst_n low during WAIT with LAT=5 -> no ack; all registers read back their reset values.
